// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commit-stage trap/ERTN sequencer driving CSR strobes, pipeline flush and fetch redirect.
module exc_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             wb_ex_req,
  input  logic [5:0]       wb_ex_ecode,
  input  logic [8:0]       wb_ex_esubcode,
  input  logic             wb_ertn,
  input  logic             wb_csr_we,
  input  logic             has_int,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      era,
  output logic             csr_wb_ex,
  output logic             csr_ertn_flush,
  output logic [5:0]       csr_ecode,
  output logic [8:0]       csr_esubcode,
  output logic [31:0]      csr_pc,
  output logic             csr_we_gated,
  output logic             wb_commit,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             busy,
  output logic [CNT_W-1:0] trap_count
);
  localparam int DW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  state_t state_q, state_d;
  logic flush_q, flush_d, redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;
  logic [DW-1:0] drain_q, drain_d;
  logic idle, ev_int, ev_ex, ev_ertn, ev_trap;
  // Interrupt outranks exception, which outranks ERTN; nothing is seen while busy.
  assign idle    = state_q == IDLE;
  assign ev_int  = idle & wb_valid & has_int;
  assign ev_ex   = idle & wb_valid & ~has_int & wb_ex_req;
  assign ev_ertn = idle & wb_valid & ~has_int & ~wb_ex_req & wb_ertn;
  assign ev_trap = ev_int | ev_ex;
  assign csr_wb_ex      = ev_trap;
  assign csr_ertn_flush = ev_ertn;
  assign csr_ecode      = ev_ex ? wb_ex_ecode : '0;
  assign csr_esubcode   = ev_ex ? wb_ex_esubcode : '0;
  assign csr_pc         = wb_pc;
  assign wb_commit      = idle & wb_valid & ~ev_trap & ~ev_ertn;
  assign csr_we_gated   = wb_commit & wb_csr_we;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_count     = trap_count_q;
  assign busy           = ~idle;
  always_comb begin
    state_d          = state_q;
    flush_d          = flush_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    trap_count_d     = trap_count_q;
    drain_d          = drain_q;
    case (state_q)
      IDLE: if (ev_trap || ev_ertn) begin
        state_d          = REDIRECT;
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = ev_ertn ? era : ex_entry;
        trap_count_d     = ev_trap && trap_count_q != '1 ? trap_count_q + 1'b1 : trap_count_q;
      end
      REDIRECT: if (redirect_ready) begin
        redirect_valid_d = 1'b0;
        if (DRAIN_CYCLES > 0) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_count_q     <= '0;
      drain_q          <= '0;
    end else begin
      state_q          <= state_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_count_q     <= trap_count_d;
      drain_q          <= drain_d;
    end
  end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: table vectors, hand sequences and random traffic on two parameterisations vs a phase model.
module tb_exc_commit_ctrl;
  logic clk, resetn, wb_valid, wb_ex_req, wb_ertn, wb_csr_we, has_int, redirect_ready;
  logic [31:0] wb_pc, ex_entry, era;
  logic [5:0] wb_ex_ecode;
  logic [8:0] wb_ex_esubcode;
  logic o_wb_ex[2], o_ertn[2], o_we[2], o_commit[2], o_flush[2], o_rv[2], o_busy[2];
  logic [5:0] o_ecode[2];
  logic [8:0] o_esub[2];
  logic [31:0] o_pc[2], o_rpc[2];
  logic [15:0] o_cnt0;
  logic [1:0] o_cnt1;
  int n_run = 0, n_fail = 0;
  bit chk_on = 0;
  bit wait_m[2];
  int post_m[2], cnt_m[2];
  bit [31:0] pc_m[2];

  exc_commit_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) u0 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex_req(wb_ex_req),
    .wb_ex_ecode(wb_ex_ecode), .wb_ex_esubcode(wb_ex_esubcode), .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we),
    .has_int(has_int), .ex_entry(ex_entry), .era(era), .csr_wb_ex(o_wb_ex[0]), .csr_ertn_flush(o_ertn[0]),
    .csr_ecode(o_ecode[0]), .csr_esubcode(o_esub[0]), .csr_pc(o_pc[0]), .csr_we_gated(o_we[0]),
    .wb_commit(o_commit[0]), .flush(o_flush[0]), .redirect_valid(o_rv[0]), .redirect_pc(o_rpc[0]),
    .redirect_ready(redirect_ready), .busy(o_busy[0]), .trap_count(o_cnt0));
  exc_commit_ctrl #(.DRAIN_CYCLES(0), .CNT_W(2)) u1 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex_req(wb_ex_req),
    .wb_ex_ecode(wb_ex_ecode), .wb_ex_esubcode(wb_ex_esubcode), .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we),
    .has_int(has_int), .ex_entry(ex_entry), .era(era), .csr_wb_ex(o_wb_ex[1]), .csr_ertn_flush(o_ertn[1]),
    .csr_ecode(o_ecode[1]), .csr_esubcode(o_esub[1]), .csr_pc(o_pc[1]), .csr_we_gated(o_we[1]),
    .wb_commit(o_commit[1]), .flush(o_flush[1]), .redirect_valid(o_rv[1]), .redirect_pc(o_rpc[1]),
    .redirect_ready(redirect_ready), .busy(o_busy[1]), .trap_count(o_cnt1));

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: "waiting for fetch" flag plus a count of post-handshake flush cycles still owed.
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        wait_m[k] <= 0; post_m[k] <= 0; pc_m[k] <= 0; cnt_m[k] <= 0;
      end else if (wait_m[k]) begin
        if (redirect_ready) begin wait_m[k] <= 0; post_m[k] <= k ? 0 : 2; end
      end else if (post_m[k] > 0) post_m[k] <= post_m[k] - 1;
      else if (wb_valid) begin
        if (has_int || wb_ex_req || wb_ertn) begin
          wait_m[k] <= 1;
          pc_m[k] <= (has_int || wb_ex_req) ? ex_entry : era;
        end
        if ((has_int || wb_ex_req) && cnt_m[k] < (k ? 3 : 65535)) cnt_m[k] <= cnt_m[k] + 1;
      end
    end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit bz, ev, tr, ex, er;
      bz = wait_m[k] || post_m[k] > 0;
      ev = wb_valid && !bz;
      tr = ev && (has_int || wb_ex_req);
      ex = tr && !has_int;
      er = ev && !tr && wb_ertn;
      chk("csr_wb_ex", k, o_wb_ex[k], tr);
      chk("csr_ertn_flush", k, o_ertn[k], er);
      chk("csr_ecode", k, o_ecode[k], ex ? wb_ex_ecode : 0);
      chk("csr_esubcode", k, o_esub[k], ex ? wb_ex_esubcode : 0);
      chk("csr_pc", k, o_pc[k], wb_pc);
      chk("wb_commit", k, o_commit[k], ev && !tr && !er);
      chk("csr_we_gated", k, o_we[k], ev && !tr && !er && wb_csr_we);
      chk("flush", k, o_flush[k], bz);
      chk("busy", k, o_busy[k], bz);
      chk("redirect_valid", k, o_rv[k], wait_m[k]);
      chk("redirect_pc", k, o_rpc[k], pc_m[k]);
      chk("trap_count", k, k ? {30'b0, o_cnt1} : {16'b0, o_cnt0}, cnt_m[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (chk_on) check_all();
  endtask

  task automatic clr();
    wb_valid = 0; has_int = 0; wb_ex_req = 0; wb_ertn = 0; wb_csr_we = 0;
    wb_ex_ecode = 0; wb_ex_esubcode = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    cyc();
    resetn = 1;
    chk("rst_flush", 0, o_flush[0], 0);
    chk("rst_rv", 0, o_rv[0], 0);
    chk("rst_rpc", 0, o_rpc[0], 0);
    chk("rst_busy", 0, o_busy[0], 0);
    chk("rst_cnt", 0, o_cnt0, 0);
  endtask

  task automatic wait_idle();
    redirect_ready = 1;
    for (int i = 0; i < 20 && (o_busy[0] || o_busy[1]); i++) cyc();
    if (o_busy[0] || o_busy[1]) chk("idle_timeout", 0, 1, 0);
  endtask

  typedef struct {
    logic v, i, x, r, w;
    logic [5:0] ec;
    logic [8:0] es;
    logic e_ex, e_er;
    logic [5:0] e_ec;
    logic [8:0] e_es;
    logic e_cm, e_we, ev;
    logic [31:0] rpc;
    int cnt;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 0, 6'h0B, 9'h000, 1, 0, 6'h0B, 9'h000, 0, 0, 1, 32'h1C008000, 1};
    tbl[1] = '{1, 1, 1, 1, 1, 6'h08, 9'h005, 1, 0, 6'h00, 9'h000, 0, 0, 1, 32'h1C008000, 1};
    tbl[2] = '{1, 0, 0, 1, 1, 6'h00, 9'h000, 0, 1, 6'h00, 9'h000, 0, 0, 1, 32'h1C000200, 0};
    tbl[3] = '{1, 0, 0, 0, 1, 6'h00, 9'h000, 0, 0, 6'h00, 9'h000, 1, 1, 0, 32'h0, 0};
    tbl[4] = '{0, 1, 1, 1, 1, 6'h0B, 9'h001, 0, 0, 6'h00, 9'h000, 0, 0, 0, 32'h0, 0};
    tbl[5] = '{1, 0, 1, 1, 1, 6'h0D, 9'h1FF, 1, 0, 6'h0D, 9'h1FF, 0, 0, 1, 32'h1C008000, 1};
    tbl[6] = '{1, 0, 0, 0, 0, 6'h00, 9'h000, 0, 0, 6'h00, 9'h000, 1, 0, 0, 32'h0, 0};
    resetn = 0; clr(); redirect_ready = 1;
    wb_pc = 32'h1C000100; ex_entry = 32'h1C008000; era = 32'h1C000200;
    cyc();
    chk_on = 1;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      wb_valid = tbl[i].v; has_int = tbl[i].i; wb_ex_req = tbl[i].x; wb_ertn = tbl[i].r;
      wb_csr_we = tbl[i].w; wb_ex_ecode = tbl[i].ec; wb_ex_esubcode = tbl[i].es;
      #1;
      chk("v_wb_ex", i, o_wb_ex[0], tbl[i].e_ex);
      chk("v_ertn", i, o_ertn[0], tbl[i].e_er);
      chk("v_ecode", i, o_ecode[0], tbl[i].e_ec);
      chk("v_esub", i, o_esub[0], tbl[i].e_es);
      chk("v_pc", i, o_pc[0], 32'h1C000100);
      chk("v_commit", i, o_commit[0], tbl[i].e_cm);
      chk("v_we", i, o_we[0], tbl[i].e_we);
      cyc();
      clr();
      #1;
      chk("v_busy", i, o_busy[0], tbl[i].ev);
      chk("v_rv", i, o_rv[0], tbl[i].ev);
      if (tbl[i].ev) chk("v_rpc", i, o_rpc[0], tbl[i].rpc);
      chk("v_cnt", i, o_cnt0, tbl[i].cnt);
      wait_idle();
    end
    // Exception timeline with fetch always ready.
    do_reset();
    wb_valid = 1; wb_ex_req = 1; wb_ex_ecode = 6'h0B;
    #1;
    chk("t0_wb_ex", 0, o_wb_ex[0], 1);
    chk("t0_ecode", 0, o_ecode[0], 6'h0B);
    cyc(); clr();
    chk("t1_rv", 0, o_rv[0], 1);
    chk("t1_rpc", 0, o_rpc[0], 32'h1C008000);
    chk("t1_flush", 0, o_flush[0], 1);
    chk("t1_rv", 1, o_rv[1], 1);
    cyc();
    chk("t2_flush", 0, o_flush[0], 1);
    chk("t2_rv", 0, o_rv[0], 0);
    chk("t2_busy", 1, o_busy[1], 0);
    cyc();
    chk("t3_flush", 0, o_flush[0], 1);
    cyc();
    chk("t4_busy", 0, o_busy[0], 0);
    chk("t4_flush", 0, o_flush[0], 0);
    chk("t4_cnt", 0, o_cnt0, 1);
    // Backpressure: redirect held, in-flight trap request ignored.
    redirect_ready = 0; ex_entry = 32'h1C008040;
    wb_valid = 1; wb_ex_req = 1; wb_ex_ecode = 6'h0B;
    cyc(); clr(); ex_entry = 32'h1C009000;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin wb_valid = 1; wb_ex_req = 1; end
      #1;
      chk("bp_wb_ex", 0, o_wb_ex[0], 0);
      chk("bp_rv", 0, o_rv[0], 1);
      chk("bp_rpc", 0, o_rpc[0], 32'h1C008040);
      cyc(); clr();
    end
    chk("bp_cnt", 0, o_cnt0, 2);
    redirect_ready = 1;
    cyc();
    chk("bp_done_rv", 0, o_rv[0], 0);
    chk("bp_drain_flush", 0, o_flush[0], 1);
    // Reset while draining.
    resetn = 0;
    cyc();
    resetn = 1;
    chk("rd_flush", 0, o_flush[0], 0);
    chk("rd_busy", 0, o_busy[0], 0);
    chk("rd_cnt", 0, o_cnt0, 0);
    // Saturation of the narrow counter.
    for (int j = 0; j < 5; j++) begin
      wb_valid = 1; wb_ex_req = 1;
      cyc(); clr();
      wait_idle();
    end
    chk("sat_cnt", 1, o_cnt1, 3);
    chk("sat_cnt", 0, o_cnt0, 5);
    // Random traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      resetn = $urandom_range(0, 63) != 0;
      redirect_ready = $urandom_range(0, 3) != 0;
      wb_valid = $urandom_range(0, 3) != 0;
      has_int = $urandom_range(0, 7) == 0;
      wb_ex_req = $urandom_range(0, 2) == 0;
      wb_ertn = $urandom_range(0, 2) == 0;
      wb_csr_we = $urandom_range(0, 1) != 0;
      wb_ex_ecode = 6'($urandom); wb_ex_esubcode = 9'($urandom);
      wb_pc = $urandom; ex_entry = $urandom; era = $urandom;
      #1;
      check_all();
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
